// File: rtl/rst_seq_ctrl_if.sv
// Control/status bundle between the reset sequencer (master) and the reset
// domains plus software (slave).
interface rst_seq_ctrl_if #(
  parameter int NUM_STAGES = 4
);
  localparam int CW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_busy;
  logic                  seq_done;
  logic [CW-1:0]         cur_stage;
  logic                  timeout_err;

  modport master (
    input  soft_rst_req,
    input  stage_ack,
    output stage_rst_n,
    output seq_busy,
    output seq_done,
    output cur_stage,
    output timeout_err
  );

  modport slave (
    output soft_rst_req,
    output stage_ack,
    input  stage_rst_n,
    input  seq_busy,
    input  seq_done,
    input  cur_stage,
    input  timeout_err
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Ordered release of per-domain active-low resets with settle delay and ack gating.
// Optional ack-wait timeout with sticky error and FAULT state: define RST_SEQ_TIMEOUT_EN.

module rst_seq_ctrl_chk #(
  parameter int NUM_STAGES = 4
) (
  input logic                  clk,
  input logic                  async_rst,
  input logic [NUM_STAGES-1:0] stage_rst_n,
  input logic                  seq_busy,
  input logic                  seq_done
);
  // Released domains always form a contiguous run starting at stage 0.
  a_thermo: assert property (@(posedge clk) disable iff (async_rst)
    (((stage_rst_n + NUM_STAGES'(1'b1)) & stage_rst_n) == {NUM_STAGES{1'b0}}));

  a_busy_done: assert property (@(posedge clk) disable iff (async_rst)
    (seq_busy != seq_done));
endmodule

module rst_seq_ctrl #(
  parameter int                    NUM_STAGES     = 4,
  parameter int                    HOLD_CYCLES    = 16,
  parameter int                    STAGE_DELAY    = 8,
  parameter logic [NUM_STAGES-1:0] ACK_MASK       = {NUM_STAGES{1'b1}},
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input logic            clk,
  input logic            async_rst,
  rst_seq_ctrl_if.master bus
);
  localparam int CW       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CNT_HD   = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CNT_MAX  = (CNT_HD > TIMEOUT_CYCLES) ? CNT_HD : TIMEOUT_CYCLES;
  localparam int NW       = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [NW-1:0]         HOLD_LAST   = NW'(HOLD_CYCLES - 1);
  localparam logic [NW-1:0]         SETTLE_LAST = NW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0]         LAST_STAGE  = CW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_BIT   = NUM_STAGES'(1'b1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [NW-1:0]         TIMEOUT_LAST = NW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_SETTLE   = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_DONE     = 3'd3
`ifdef RST_SEQ_TIMEOUT_EN
    , S_FAULT  = 3'd4
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [NW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
  logic [CW-1:0]         cur_stage_q, cur_stage_d;
  logic                  seq_busy_q, seq_busy_d;
  logic                  seq_done_q, seq_done_d;
`ifdef RST_SEQ_TIMEOUT_EN
  logic                  timeout_err_q, timeout_err_d;
`endif

  logic                  ack_ok_s;
  logic                  ack_lost_s;
  logic                  eval_s;
  logic [CW-1:0]         next_stage_s;
  logic [NUM_STAGES-1:0] next_bit_s;

  // Ack condition of the awaited stage, the bit released next, and ack loss in DONE.
  always_comb begin
    ack_ok_s     = 1'b0;
    next_stage_s = cur_stage_q + CW'(1'b1);
    next_bit_s   = {NUM_STAGES{1'b0}};
    for (int i = 0; i < NUM_STAGES; i++) begin
      ack_ok_s      = ack_ok_s | ((CW'(i) == cur_stage_q) & (~ACK_MASK[i] | bus.stage_ack[i]));
      next_bit_s[i] = (CW'(i) == next_stage_s);
    end
    ack_lost_s = |(ACK_MASK & ~bus.stage_ack);
  end

  // Next-state and next-output logic; restart sources take priority over progress.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stage_rst_n_d = stage_rst_n_q;
    cur_stage_d   = cur_stage_q;
    seq_busy_d    = seq_busy_q;
    seq_done_d    = seq_done_q;
`ifdef RST_SEQ_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
`endif
    eval_s = ((state_q == S_SETTLE) && (cnt_q == SETTLE_LAST)) ||
             ((state_q == S_WAIT_ACK) && ack_ok_s);

    if (bus.soft_rst_req || ((state_q == S_DONE) && ack_lost_s)) begin
      state_d       = S_HOLD;
      cnt_d         = {NW{1'b0}};
      stage_rst_n_d = {NUM_STAGES{1'b0}};
      cur_stage_d   = {CW{1'b0}};
      seq_busy_d    = 1'b1;
      seq_done_d    = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_err_d = timeout_err_q & ~bus.soft_rst_req;
`endif
    end else if (eval_s) begin
      cnt_d = {NW{1'b0}};
      if (!ack_ok_s) begin
        state_d = S_WAIT_ACK;
      end else if (cur_stage_q == LAST_STAGE) begin
        state_d    = S_DONE;
        seq_done_d = 1'b1;
        seq_busy_d = 1'b0;
      end else begin
        state_d       = S_SETTLE;
        stage_rst_n_d = stage_rst_n_q | next_bit_s;
        cur_stage_d   = next_stage_s;
      end
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d       = S_SETTLE;
            cnt_d         = {NW{1'b0}};
            stage_rst_n_d = FIRST_BIT;
            cur_stage_d   = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + NW'(1'b1);
          end
        end
        S_SETTLE: begin
          cnt_d = cnt_q + NW'(1'b1);
        end
        S_WAIT_ACK: begin
`ifdef RST_SEQ_TIMEOUT_EN
          if (cnt_q == TIMEOUT_LAST) begin
            state_d       = S_FAULT;
            cnt_d         = {NW{1'b0}};
            timeout_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + NW'(1'b1);
          end
`else
          cnt_d = cnt_q;
`endif
        end
        S_DONE: begin
          state_d = S_DONE;
        end
`ifdef RST_SEQ_TIMEOUT_EN
        S_FAULT: begin
          state_d = S_FAULT;
        end
`endif
        default: begin
          // Unreachable encodings fall back into a clean re-sequence.
          state_d       = S_HOLD;
          cnt_d         = {NW{1'b0}};
          stage_rst_n_d = {NUM_STAGES{1'b0}};
          cur_stage_d   = {CW{1'b0}};
          seq_busy_d    = 1'b1;
          seq_done_d    = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q       <= S_HOLD;
      cnt_q         <= {NW{1'b0}};
      stage_rst_n_q <= {NUM_STAGES{1'b0}};
      cur_stage_q   <= {CW{1'b0}};
      seq_busy_q    <= 1'b1;
      seq_done_q    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_rst_n_q <= stage_rst_n_d;
      cur_stage_q   <= cur_stage_d;
      seq_busy_q    <= seq_busy_d;
      seq_done_q    <= seq_done_d;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.stage_rst_n = stage_rst_n_q;
  assign bus.cur_stage   = cur_stage_q;
  assign bus.seq_busy    = seq_busy_q;
  assign bus.seq_done    = seq_done_q;
`ifdef RST_SEQ_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  rst_seq_ctrl_chk #(.NUM_STAGES(NUM_STAGES)) u_chk (
    .clk         (clk),
    .async_rst   (async_rst),
    .stage_rst_n (stage_rst_n_q),
    .seq_busy    (seq_busy_q),
    .seq_done    (seq_done_q)
  );
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: three instances (ACK_MASK 000/010/111) checked against a
// release-timeline model, a directed vector table and hand-written corner sequences.
module tb_rst_seq_ctrl;
  localparam int NS = 3;
  localparam int H  = 4;
  localparam int D  = 2;
  localparam int T  = 5;
`ifdef RST_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [2:0] MASK0 = 3'b000;
  localparam logic [2:0] MASK1 = 3'b010;
  localparam logic [2:0] MASK2 = 3'b111;

  logic       clk = 1'b0;
  logic       async_rst = 1'b1;
  logic       soft_v  [3];
  logic [2:0] ack_v   [3];
  logic [2:0] mask_c  [3];
  logic [2:0] rst_n_o [3];
  logic [1:0] cur_o   [3];
  logic       done_o  [3];
  logic       busy_o  [3];
  logic       terr_o  [3];

  rst_seq_ctrl_if #(.NUM_STAGES(NS)) if0 ();
  rst_seq_ctrl_if #(.NUM_STAGES(NS)) if1 ();
  rst_seq_ctrl_if #(.NUM_STAGES(NS)) if2 ();

  assign if0.soft_rst_req = soft_v[0];
  assign if1.soft_rst_req = soft_v[1];
  assign if2.soft_rst_req = soft_v[2];
  assign if0.stage_ack    = ack_v[0];
  assign if1.stage_ack    = ack_v[1];
  assign if2.stage_ack    = ack_v[2];

  rst_seq_ctrl #(.NUM_STAGES(NS), .HOLD_CYCLES(H), .STAGE_DELAY(D), .ACK_MASK(MASK0),
                 .TIMEOUT_CYCLES(T)) u_m0 (.clk(clk), .async_rst(async_rst), .bus(if0));
  rst_seq_ctrl #(.NUM_STAGES(NS), .HOLD_CYCLES(H), .STAGE_DELAY(D), .ACK_MASK(MASK1),
                 .TIMEOUT_CYCLES(T)) u_m2 (.clk(clk), .async_rst(async_rst), .bus(if1));
  rst_seq_ctrl #(.NUM_STAGES(NS), .HOLD_CYCLES(H), .STAGE_DELAY(D), .ACK_MASK(MASK2),
                 .TIMEOUT_CYCLES(T)) u_m7 (.clk(clk), .async_rst(async_rst), .bus(if2));

  assign rst_n_o[0] = if0.stage_rst_n;
  assign rst_n_o[1] = if1.stage_rst_n;
  assign rst_n_o[2] = if2.stage_rst_n;
  assign cur_o[0]   = if0.cur_stage;
  assign cur_o[1]   = if1.cur_stage;
  assign cur_o[2]   = if2.cur_stage;
  assign done_o[0]  = if0.seq_done;
  assign done_o[1]  = if1.seq_done;
  assign done_o[2]  = if2.seq_done;
  assign busy_o[0]  = if0.seq_busy;
  assign busy_o[1]  = if1.seq_busy;
  assign busy_o[2]  = if2.seq_busy;
  assign terr_o[0]  = if0.timeout_err;
  assign terr_o[1]  = if1.timeout_err;
  assign terr_o[2]  = if2.timeout_err;

  always #5 clk = ~clk;

  // Reference model: per instance, the edge at which the sequence (re)started and
  // the edge at which each stage was released (-1 = still held).
  int n;
  int base_m [3];
  int rel_m  [3][3];
  bit done_m [3];
  bit fault_m[3];
  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int         edge_n;
    logic [2:0] r0;
    logic       d0;
    logic [2:0] r1;
    logic       d1;
    logic [2:0] r2;
    logic       t2;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, n, act, exp);
  endtask

  task automatic model_restart(input int d);
    base_m[d] = n;
    done_m[d] = 1'b0;
    for (int i = 0; i < NS; i++) rel_m[d][i] = -1;
  endtask

  task automatic model_reset_all();
    n = 0;
    for (int d = 0; d < 3; d++) begin
      model_restart(d);
      fault_m[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d);
    int k;
    int i;
    k = 0;
    for (int s = 0; s < NS; s++) if (rel_m[d][s] >= 0) k++;
    if (soft_v[d]) begin
      model_restart(d);
      fault_m[d] = 1'b0;
    end else if (done_m[d] && ((mask_c[d] & ~ack_v[d]) != 3'b000)) begin
      model_restart(d);
    end else if (done_m[d] || fault_m[d]) begin
      k = k;
    end else if (k == 0) begin
      if (n == base_m[d] + H) rel_m[d][0] = n;
    end else begin
      i = k - 1;
      if (n >= rel_m[d][i] + D) begin
        if (!mask_c[d][i] || ack_v[d][i]) begin
          if (i < NS - 1) rel_m[d][i+1] = n;
          else done_m[d] = 1'b1;
        end else if (TO_EN && (n >= rel_m[d][i] + D + T)) begin
          fault_m[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_model(input int d);
    logic [2:0] er;
    int k;
    er = 3'b000;
    k  = 0;
    for (int i = 0; i < NS; i++) begin
      if (rel_m[d][i] >= 0) begin
        er[i] = 1'b1;
        k++;
      end
    end
    check("model_stage_rst_n", d, 32'(rst_n_o[d]), 32'(er));
    check("model_cur_stage",   d, 32'(cur_o[d]),   32'((k == 0) ? 0 : k - 1));
    check("model_seq_done",    d, 32'(done_o[d]),  32'(done_m[d]));
    check("model_seq_busy",    d, 32'(busy_o[d]),  32'(!done_m[d]));
    check("model_timeout_err", d, 32'(terr_o[d]),  32'(fault_m[d]));
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    for (int d = 0; d < 3; d++) model_edge(d);
    #1;
    for (int d = 0; d < 3; d++) compare_model(d);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check({tag, "_stage_rst_n"}, d, 32'(rst_n_o[d]), 32'd0);
    check({tag, "_seq_done"},    d, 32'(done_o[d]),  32'd0);
    check({tag, "_seq_busy"},    d, 32'(busy_o[d]),  32'd1);
    check({tag, "_cur_stage"},   d, 32'(cur_o[d]),   32'd0);
    check({tag, "_timeout_err"}, d, 32'(terr_o[d]),  32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mask_c[0] = MASK0;
    mask_c[1] = MASK1;
    mask_c[2] = MASK2;
    for (int d = 0; d < 3; d++) soft_v[d] = 1'b0;
    ack_v[0] = 3'b000;
    ack_v[1] = 3'b000;
    ack_v[2] = 3'b001;

    vecs[0] = '{3,  3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
    vecs[1] = '{4,  3'b001, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0};
    vecs[2] = '{5,  3'b001, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0};
    vecs[3] = '{6,  3'b011, 1'b0, 3'b011, 1'b0, 3'b011, 1'b0};
    vecs[4] = '{8,  3'b111, 1'b0, 3'b011, 1'b0, 3'b011, 1'b0};
    vecs[5] = '{10, 3'b111, 1'b1, 3'b011, 1'b0, 3'b011, 1'b0};
    vecs[6] = '{11, 3'b111, 1'b1, 3'b111, 1'b0, 3'b011, 1'b0};
    vecs[7] = '{12, 3'b111, 1'b1, 3'b111, 1'b0, 3'b011, 1'b0};
    vecs[8] = '{13, 3'b111, 1'b1, 3'b111, 1'b1, 3'b011, TO_EN};
    vecs[9] = '{14, 3'b111, 1'b1, 3'b111, 1'b1, 3'b011, TO_EN};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_reset_vals(d, "por");
    async_rst = 1'b0;
    model_reset_all();

    // Directed bring-up: mask 000 free-runs, mask 010 waits for ack[1], mask 111 stalls on ack[1].
    for (int v = 0; v < 10; v++) begin
      while (n < vecs[v].edge_n) begin
        if (n == 10) ack_v[1] = 3'b010;
        step();
      end
      check("vec_rst_n_m0", 0, 32'(rst_n_o[0]), 32'(vecs[v].r0));
      check("vec_done_m0",  0, 32'(done_o[0]),  32'(vecs[v].d0));
      check("vec_busy_m0",  0, 32'(busy_o[0]),  32'(!vecs[v].d0));
      check("vec_rst_n_m2", 1, 32'(rst_n_o[1]), 32'(vecs[v].r1));
      check("vec_done_m2",  1, 32'(done_o[1]),  32'(vecs[v].d1));
      check("vec_rst_n_m7", 2, 32'(rst_n_o[2]), 32'(vecs[v].r2));
      check("vec_terr_m7",  2, 32'(terr_o[2]),  32'(vecs[v].t2));
    end

    // Soft re-sequence: 3-cycle request on m0 in DONE, 1-cycle request on m7 (clears timeout).
    soft_v[0] = 1'b1;
    soft_v[2] = 1'b1;
    step();
    check("soft_rst_n_m0", 0, 32'(rst_n_o[0]), 32'd0);
    check("soft_done_m0",  0, 32'(done_o[0]),  32'd0);
    check("soft_rst_n_m7", 2, 32'(rst_n_o[2]), 32'd0);
    check("soft_terr_m7",  2, 32'(terr_o[2]),  32'd0);
    soft_v[2] = 1'b0;
    ack_v[2]  = 3'b111;
    step();
    step();
    soft_v[0] = 1'b0;
    repeat (3) step();
    check("soft_hold_m0", 0, 32'(rst_n_o[0]), 32'd0);
    step();
    check("soft_rel0_m0", 0, 32'(rst_n_o[0]), 32'd1);
    while (n < 25) step();
    check("acks_done_m7", 2, 32'(done_o[2]), 32'd1);

    // Lost ack in DONE restarts the whole sequence.
    ack_v[2] = 3'b110;
    step();
    check("acklost_rst_n_m7", 2, 32'(rst_n_o[2]), 32'd0);
    check("acklost_done_m7",  2, 32'(done_o[2]),  32'd0);
    ack_v[2] = 3'b111;
    while (n < 29) step();
    check("acklost_hold_m7", 2, 32'(rst_n_o[2]), 32'd0);
    step();
    check("acklost_rel0_m7", 2, 32'(rst_n_o[2]), 32'd1);

    // Random soft requests and ack toggles against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 3; d++) begin
        soft_v[d] = ($urandom_range(0, 63) == 32'd0);
        for (int b = 0; b < NS; b++) begin
          if ($urandom_range(0, 15) == 32'd0) ack_v[d][b] = ~ack_v[d][b];
        end
      end
      step();
    end

    // Asynchronous reset in the middle of stage 1 settle, with no clock edge.
    for (int d = 0; d < 3; d++) soft_v[d] = 1'b0;
    ack_v[0] = 3'b000;
    ack_v[1] = 3'b010;
    ack_v[2] = 3'b111;
    async_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    async_rst = 1'b0;
    model_reset_all();
    while (n < 7) step();
    check("pre_async_rst_n_m0", 0, 32'(rst_n_o[0]), 32'd3);
    #2;
    async_rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) check_reset_vals(d, "async");
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
